// File: rtl/ps2_move_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_move_decoder_if
//  Description : Move-request channel between the PS/2 move decoder and the
//                maze position FSM. One request at a time; a transfer takes
//                place on a clock edge where move_valid and move_ready are
//                both high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_move_decoder_if;
  logic       move_valid;  // request pending
  logic [1:0] move_dir;    // 00 up, 01 down, 10 left, 11 right
  logic       move_ready;  // consumer can take the request

  // Decoder side: produces requests.
  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  // Position FSM side: consumes requests.
  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );
endinterface
`default_nettype wire

// File: rtl/ps2_move_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_move_decoder
//  Description : Turns PS/2 scan-code bytes into single WASD move requests.
//                Handles the F0 break and E0 extended prefixes, drops
//                typematic repeats using per-key held flags, abandons a
//                prefix after PREFIX_TIMEOUT quiet cycles, and buffers one
//                request behind a valid/ready handshake.
//  Options     : ARROW_KEYS_EN - when defined, E0-prefixed arrow keys act
//                exactly like W/S/A/D. When undefined, extended codes are
//                swallowed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_move_decoder #(
  parameter int PREFIX_TIMEOUT = 50000,  // quiet cycles before a prefix is abandoned
  parameter int TO_W           = 16      // timeout counter width
) (
  input  wire                        CLOCK_50,
  input  wire                        resetn,
  input  wire  [7:0]                 ps2_data,
  input  wire                        ps2_data_en,
  input  wire                        game_over,
  ps2_move_decoder_if.master         move_if,
  output logic [3:0]                 key_held,
  output logic [7:0]                 drop_count
);

  localparam logic [7:0]      c_break_code = 8'hF0;
  localparam logic [7:0]      c_ext_code   = 8'hE0;
  // Counts down to zero, so the timeout fires after exactly PREFIX_TIMEOUT
  // quiet cycles spent in a prefix state.
  localparam logic [TO_W-1:0] c_to_load    = TO_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]      held_q, held_d;
  logic            valid_q, valid_d;
  logic [1:0]      dir_q, dir_d;
  logic [7:0]      drop_q, drop_d;

  // Decoder outputs towards the request slot.
  logic            req;
  logic [1:0]      req_dir;
  logic            fire;

  // Plain key lookup. The held-bit index equals the direction code, so one
  // value serves both purposes.
  logic            std_hit;
  logic [1:0]      std_idx;

  // Map a plain (non-extended) scan code to its key index.
  always_comb begin
    std_hit = 1'b1;
    std_idx = 2'd0;
    case (ps2_data)
      8'h1D:   std_idx = 2'd0;  // W -> up
      8'h1B:   std_idx = 2'd1;  // S -> down
      8'h1C:   std_idx = 2'd2;  // A -> left
      8'h23:   std_idx = 2'd3;  // D -> right
      default: std_hit = 1'b0;
    endcase
  end

`ifdef ARROW_KEYS_EN
  logic            ext_hit;
  logic [1:0]      ext_idx;

  // Map the second byte of an E0 sequence to the matching WASD index.
  always_comb begin
    ext_hit = 1'b1;
    ext_idx = 2'd0;
    case (ps2_data)
      8'h75:   ext_idx = 2'd0;  // up arrow
      8'h72:   ext_idx = 2'd1;  // down arrow
      8'h6B:   ext_idx = 2'd2;  // left arrow
      8'h74:   ext_idx = 2'd3;  // right arrow
      default: ext_hit = 1'b0;
    endcase
  end
`endif

  // Prefix FSM: next state, timeout counter, held flags and request strobe.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    held_d   = held_q;
    req      = 1'b0;
    req_dir  = 2'd0;

    if (ps2_data_en) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_data == c_break_code) begin
            state_d  = S_BREAK;
            to_cnt_d = c_to_load;
          end else if (ps2_data == c_ext_code) begin
            state_d  = S_EXT;
            to_cnt_d = c_to_load;
          end else if (std_hit && !held_q[std_idx]) begin
            // First make of a released key; a set bit means typematic repeat.
            held_d[std_idx] = 1'b1;
            req             = 1'b1;
            req_dir         = std_idx;
          end
        end
        S_BREAK: begin
          // Whatever the byte is, the break sequence ends here.
          if (std_hit) held_d[std_idx] = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT: begin
          if (ps2_data == c_break_code) begin
            state_d  = S_EXT_BREAK;
            to_cnt_d = c_to_load;
          end else begin
`ifdef ARROW_KEYS_EN
            if (ext_hit && !held_q[ext_idx]) begin
              held_d[ext_idx] = 1'b1;
              req             = 1'b1;
              req_dir         = ext_idx;
            end
`endif
            // Without arrow support the byte is consumed here so that e.g.
            // E0 6B is never seen as a plain make code.
            state_d = S_IDLE;
          end
        end
        S_EXT_BREAK: begin
`ifdef ARROW_KEYS_EN
          if (ext_hit) held_d[ext_idx] = 1'b0;
`endif
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // Quiet cycle inside a prefix: count down, abandon on expiry.
      if (to_cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q - TO_W'(1);
      end
    end
  end

  assign fire = valid_q & move_if.move_ready;

  // One-deep request slot with drop accounting and game-over suppression.
  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    drop_d  = drop_q;

    if (game_over) begin
      // Requests are discarded outright; they are not drops.
      valid_d = 1'b0;
    end else if (req) begin
      if (!valid_q || fire) begin
        valid_d = 1'b1;
        dir_d   = req_dir;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      held_q   <= 4'b0000;
      valid_q  <= 1'b0;
      dir_q    <= 2'b00;
      drop_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      held_q   <= held_d;
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      drop_q   <= drop_d;
    end
  end

  assign move_if.move_valid = valid_q;
  assign move_if.move_dir   = dir_q;
  assign key_held           = held_q;
  assign drop_count         = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_move_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_move_decoder
//  Description : Directed self-checking bench for ps2_move_decoder. Inputs
//                change on the falling edge; outputs are checked on the
//                falling edge, half a cycle after the capturing rising edge.
//                Follows ARROW_KEYS_EN for the extended-key expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_move_decoder;

  logic       clk;
  logic       resetn;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       game_over;
  logic [3:0] key_held;
  logic [7:0] drop_count;

  int vectors;
  int miscompares;

  ps2_move_decoder_if mif ();

  ps2_move_decoder #(
    .PREFIX_TIMEOUT (50000),
    .TO_W           (16)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .ps2_data    (ps2_data),
    .ps2_data_en (ps2_data_en),
    .game_over   (game_over),
    .move_if     (mif.master),
    .key_held    (key_held),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte for one cycle; returns on the falling edge after capture.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_data    = b;
    ps2_data_en = 1'b1;
    @(negedge clk);
    ps2_data_en = 1'b0;
  endtask

  // Hold move_ready high for exactly one cycle.
  task automatic pulse_ready();
    @(negedge clk);
    mif.move_ready = 1'b1;
    @(negedge clk);
    mif.move_ready = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    resetn         = 1'b0;
    ps2_data       = 8'h1D;
    ps2_data_en    = 1'b1;  // strobe during reset must be ignored
    game_over      = 1'b0;
    mif.move_ready = 1'b0;

    repeat (3) @(negedge clk);
    ps2_data_en = 1'b0;
    resetn      = 1'b1;
    check("reset_valid", 32'(mif.move_valid), 32'h0);
    check("reset_dir",   32'(mif.move_dir),   32'h0);
    check("reset_held",  32'(key_held),       32'h0);
    check("reset_drop",  32'(drop_count),     32'h0);

    // W make, then typematic repeat with the slot full.
    send(8'h1D);
    check("w_valid", 32'(mif.move_valid), 32'h1);
    check("w_dir",   32'(mif.move_dir),   32'h0);
    check("w_held",  32'(key_held),       32'h1);
    send(8'h1D);
    check("w_rep_drop",  32'(drop_count),     32'h0);
    check("w_rep_held",  32'(key_held),       32'h1);
    check("w_rep_valid", 32'(mif.move_valid), 32'h1);
    pulse_ready();
    check("w_xfer_valid", 32'(mif.move_valid), 32'h0);
    send(8'hF0);
    send(8'h1D);
    check("w_release_held", 32'(key_held), 32'h0);

    // A make / break / make with the consumer always ready.
    mif.move_ready = 1'b1;
    send(8'h1C);
    check("a1_valid", 32'(mif.move_valid), 32'h1);
    check("a1_dir",   32'(mif.move_dir),   32'h2);
    check("a1_held",  32'(key_held),       32'h4);
    @(negedge clk);
    check("a1_done",  32'(mif.move_valid), 32'h0);
    send(8'hF0);
    send(8'h1C);
    check("a_break_held",  32'(key_held),       32'h0);
    check("a_break_valid", 32'(mif.move_valid), 32'h0);
    send(8'h1C);
    check("a2_valid", 32'(mif.move_valid), 32'h1);
    check("a2_dir",   32'(mif.move_dir),   32'h2);
    check("a2_held",  32'(key_held),       32'h4);
    @(negedge clk);
    check("a2_done",  32'(mif.move_valid), 32'h0);
    mif.move_ready = 1'b0;
    send(8'hF0);
    send(8'h1C);

    // Slot full: D request held, later S request dropped.
    send(8'h23);
    check("d_dir", 32'(mif.move_dir), 32'h3);
    send(8'hF0);
    send(8'h23);
    send(8'h1B);
    check("drop_dir",   32'(mif.move_dir),   32'h3);
    check("drop_valid", 32'(mif.move_valid), 32'h1);
    check("drop_count", 32'(drop_count),     32'h1);
    check("drop_held",  32'(key_held),       32'h2);
    pulse_ready();
    check("drop_xfer_valid", 32'(mif.move_valid), 32'h0);
    send(8'hF0);
    send(8'h1B);
    check("s_release_held", 32'(key_held), 32'h0);

    // Abandoned break prefix: after the timeout 1D is a make.
    send(8'hF0);
    repeat (50000) @(negedge clk);
    send(8'h1D);
    check("to_valid", 32'(mif.move_valid), 32'h1);
    check("to_dir",   32'(mif.move_dir),   32'h0);
    check("to_held",  32'(key_held),       32'h1);
    pulse_ready();
    send(8'hF0);
    send(8'h1D);
    check("to_release_held", 32'(key_held), 32'h0);

    // Extended left arrow.
    send(8'hE0);
    send(8'h6B);
`ifdef ARROW_KEYS_EN
    check("ext_valid", 32'(mif.move_valid), 32'h1);
    check("ext_dir",   32'(mif.move_dir),   32'h2);
    check("ext_held",  32'(key_held),       32'h4);
    pulse_ready();
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("ext_break_held", 32'(key_held), 32'h0);
`else
    check("ext_valid", 32'(mif.move_valid), 32'h0);
    check("ext_held",  32'(key_held),       32'h0);
`endif

    // Game over with a full slot, then reset.
    send(8'h1B);
    check("go_pre_dir", 32'(mif.move_dir), 32'h1);
    @(negedge clk);
    game_over   = 1'b1;
    ps2_data    = 8'h23;
    ps2_data_en = 1'b1;
    @(negedge clk);
    ps2_data_en = 1'b0;
    check("go_valid", 32'(mif.move_valid), 32'h0);
    check("go_drop",  32'(drop_count),     32'h1);
    check("go_held",  32'(key_held),       32'hA);
    resetn = 1'b0;
    @(negedge clk);
    resetn    = 1'b1;
    game_over = 1'b0;
    check("rst2_valid", 32'(mif.move_valid), 32'h0);
    check("rst2_dir",   32'(mif.move_dir),   32'h0);
    check("rst2_held",  32'(key_held),       32'h0);
    check("rst2_drop",  32'(drop_count),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Upstream stage of the maze position controller. Consumes raw PS/2 scan-code bytes from the PS/2 controller and turns WASD key presses into single move requests.
- Decodes the F0 break prefix and the E0 extended prefix, and suppresses typematic auto-repeat.
- Presents one buffered move request through a valid/ready handshake, so the position FSM sees exactly one request per physical key press.

Parameters:
- PREFIX_TIMEOUT, 50000, cycles allowed between a prefix byte (E0/F0) and its following byte before the decoder abandons the sequence (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter. Must hold PREFIX_TIMEOUT.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  synchronous active-low reset.
- ps2_data  input  8  received scan-code byte, valid while ps2_data_en is high.
- ps2_data_en  input  1  one-cycle strobe per received byte.
- game_over  input  1  game finished; move requests are suppressed while high.
- move_ready  input  1  downstream position FSM can accept a request.
- move_valid  output  1  move request pending.
- move_dir  output  2  direction: 00 up, 01 down, 10 left, 11 right.
- key_held  output  4  held flags, bit0 W/up, bit1 S/down, bit2 A/left, bit3 D/right.
- drop_count  output  8  saturating count of requests lost because the output slot was full.

Behaviour:
- Reset: resetn is synchronous and active-low, clocked on CLOCK_50. On reset:
  - move_valid=0, move_dir=00, key_held=0000, drop_count=00.
  - FSM returns to S_IDLE and the timeout counter is cleared.
- Key map:
  - W=1D maps to up/bit0.
  - S=1B maps to down/bit1.
  - A=1C maps to left/bit2.
  - D=23 maps to right/bit3.
- FSM states and transitions. Transitions occur only on cycles where ps2_data_en=1, except for the timeout.
  - S_IDLE:
    - F0 -> S_BREAK.
    - E0 -> S_EXT.
    - Mapped make code: if its held bit is 0, set the bit and raise a request. If its held bit is 1, this is a typematic repeat and is ignored. Stay in S_IDLE.
    - Any other byte is ignored.
  - S_BREAK:
    - Mapped code clears its held bit (clearing a bit that is already 0 is harmless).
    - Any byte, including F0 or E0, returns the FSM to S_IDLE.
    - No request is raised.
  - S_EXT:
    - F0 -> S_EXT_BREAK.
    - Otherwise the byte is handled as an extended make code (see Optional Feature), then -> S_IDLE.
  - S_EXT_BREAK: the byte is handled as an extended break code, then -> S_IDLE.
  - Timeout: in any prefix state, if PREFIX_TIMEOUT cycles pass with no byte, return to S_IDLE. The counter reloads on every entry into a prefix state.
- Request slot (one entry deep):
  - Latency: a make byte strobed in cycle N gives move_valid=1 with the correct move_dir in cycle N+1.
  - move_valid and move_dir hold steady until a cycle where move_valid=1 and move_ready=1; the transfer completes on that edge.
  - A new request in the same cycle as a transfer loads the slot, so move_valid stays 1 and move_dir takes the new value.
  - A new request while the slot is full and not transferring is dropped. drop_count increments and saturates at FF.
- game_over=1:
  - move_valid is cleared on the next edge.
  - New requests are discarded and do not count as drops.
  - Held-flag tracking and FSM decoding continue normally.
- ps2_data_en arriving during reset has no effect.

Optional Feature:
- Macro ARROW_KEYS_EN.
- Defined: extended codes E0 75 (up), E0 72 (down), E0 6B (left), E0 74 (right) act exactly like W/S/A/D. They share the same held bits and requests, and E0 F0 xx clears the matching bit.
- Undefined: extended bytes are consumed and ignored, and the FSM returns to S_IDLE. In particular, E0 6B must not be read as a plain make code.

Test Plan:
- Reset, then bytes 1D, then 1D, with move_ready=0 -> move_valid=1 and move_dir=00 from the cycle after the first strobe. The second 1D is ignored: drop_count stays 00 and key_held=0001.
- Bytes 1C, F0, 1C, then 1C again, with move_ready=1 -> two single-cycle transfers, both move_dir=10. key_held goes 0100, then 0000, then 0100.
- move_ready=0, bytes 23, F0, 23, 1B -> slot keeps move_dir=11, drop_count=01. Then pulse move_ready=1 -> move_valid=0 next cycle.
- Byte F0, then idle for 50000 cycles, then 1D -> 1D is treated as a make code: request up, key_held=0001.
- Byte E0, then 6B -> with ARROW_KEYS_EN: move_dir=10. Without it: no request, key_held=0000.
- Slot full with move_dir=01, then game_over=1 and byte 23 -> move_valid=0 next cycle, drop_count unchanged, key_held bit3=1. Then resetn=0 for one cycle -> all outputs zero.
